// File: rtl/usart_tx_fifo_if.sv
// usart_tx_fifo_if
//   Write-side bundle of the FIFO-backed serial transmitter.
//   master : upstream producer (drives data/send, observes ready/overflow/fifo_count)
//   slave  : the transmitter itself
//   data       - word to queue, DATA_BITS wide
//   send       - write strobe, accepted when send & ready
//   ready      - FIFO not full
//   overflow   - one-cycle pulse after a refused send
//   fifo_count - number of queued words
interface usart_tx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
);
    logic [DATA_BITS-1:0]            data;
    logic                            send;
    logic                            ready;
    logic                            overflow;
    logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count;

    modport master (
        output data,
        output send,
        input  ready,
        input  overflow,
        input  fifo_count
    );

    modport slave (
        input  data,
        input  send,
        output ready,
        output overflow,
        output fifo_count
    );
endinterface

// File: rtl/usart_tx_fifo.sv
// usart_tx_fifo
//   Asynchronous serial transmitter with a built-in transmit FIFO.
//   Frame: start(0), DATA_BITS LSB first, optional parity, STOP_BITS stop(1).
//   Each bit lasts DIV = CLK_FREQ/BAUD_RATE clocks. Queued words are sent
//   back-to-back with no idle gap between frames.
//   Ports:
//     clock  - sole clock, rising edge
//     reset  - asynchronous, active-high; discards queued and in-flight words
//     bus    - write-side handshake (data, send, ready, overflow, fifo_count)
//     busy   - frame in progress
//     tx     - serial line, idle high
//     tx_led - high when nothing is in flight or queued
module usart_tx_fifo #(
    parameter int CLK_FREQ   = 16000000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic           clock,
    input  logic           reset,
    usart_tx_fifo_if.slave bus,
    output logic           busy,
    output logic           tx,
    output logic           tx_led
);
    localparam int DIV = CLK_FREQ / BAUD_RATE;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);

    localparam logic [15:0]   DIV_M1    = 16'(DIV - 1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);

    // Elaboration-time parameter checks.
    if (DIV < 2 || DIV > 65535) begin : g_bad_div
        $error("usart_tx_fifo: CLK_FREQ/BAUD_RATE must lie in 2..65535");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("usart_tx_fifo: DATA_BITS must lie in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("usart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("usart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("usart_tx_fifo: FIFO_DEPTH must be a power of 2, >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic                 overflow_q;
    logic                 ready;
    logic                 push;
    logic                 pop;
    logic [DATA_BITS-1:0] head;

    // Full refuses a push even when a pop happens in the same cycle.
    assign ready = (count != FULL);
    assign push  = bus.send & ready;
    assign head  = mem[rd_ptr];

    // NOTE: storage carries no reset; only pointers and count do, and they
    // alone decide which entries are valid.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= bus.data;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of process order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            overflow_q <= bus.send & ~ready;
        end
    end

    assign bus.ready      = ready;
    assign bus.overflow   = overflow_q;
    assign bus.fifo_count = count;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t               state,    state_n;
    logic [DATA_BITS-1:0] shift,    shift_n;
    logic [15:0]          baud_cnt, baud_n;
    logic [3:0]           bit_idx,  bit_n;
    logic                 par_bit,  par_n;
    logic                 tx_q,     tx_n;
    logic                 tick;
    logic                 load;

    assign tick = (baud_cnt == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            shift    <= '0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            par_bit  <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state    <= state_n;
            shift    <= shift_n;
            baud_cnt <= baud_n;
            bit_idx  <= bit_n;
            par_bit  <= par_n;
            tx_q     <= tx_n;
        end
    end

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would infer a latch.
    always_comb begin
        state_n = state;
        shift_n = shift;
        baud_n  = baud_cnt;
        bit_n   = bit_idx;
        par_n   = par_bit;
        tx_n    = tx_q;
        load    = 1'b0;

        // Within a bit the counter just runs down; decisions happen at zero.
        if (state != S_IDLE && !tick) begin
            baud_n = baud_cnt - 1'b1;
        end

        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    load = 1'b1;
                end
            end
            S_START: begin
                if (tick) begin
                    state_n = S_DATA;
                    tx_n    = shift[0];
                    baud_n  = DIV_M1;
                    bit_n   = '0;
                end
            end
            S_DATA: begin
                if (tick) begin
                    baud_n = DIV_M1;
                    if (bit_idx == LAST_DATA) begin
                        if (PARITY != 0) begin
                            state_n = S_PARITY;
                            tx_n    = par_bit;
                        end else begin
                            state_n = S_STOP;
                            tx_n    = 1'b1;
                            bit_n   = '0;
                        end
                    end else begin
                        shift_n = shift >> 1;
                        tx_n    = shift_n[0];
                        bit_n   = bit_idx + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    state_n = S_STOP;
                    tx_n    = 1'b1;
                    baud_n  = DIV_M1;
                    bit_n   = '0;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (bit_idx == LAST_STOP) begin
                        // Chain straight into the next frame when words wait.
                        if (count != '0) begin
                            load = 1'b1;
                        end else begin
                            state_n = S_IDLE;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        bit_n  = bit_idx + 1'b1;
                        baud_n = DIV_M1;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
                tx_n    = 1'b1;
            end
        endcase

        // Frame load: pop the head, precompute parity, drive the start bit.
        if (load) begin
            state_n = S_START;
            shift_n = head;
            par_n   = (PARITY == 1) ? ~(^head) : (^head);
            tx_n    = 1'b0;
            baud_n  = DIV_M1;
            bit_n   = '0;
        end
    end

    assign pop    = load;
    assign busy   = (state != S_IDLE);
    assign tx     = tx_q;
    assign tx_led = ~busy & (count == '0);
endmodule

// File: tb/tb_usart_tx_fifo.sv
// tb_usart_tx_fifo
//   Three transmitter instances at DIV=4: 8N1 (depth 4), 8E2 and 7O1.
//   Expected frames are built by a reference function and queued when a word
//   is sent; a line monitor reconstructs every frame from tx and compares it
//   against the head of the matching queue.
module tb_usart_tx_fifo;
    localparam int DIV = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clock = ~clock;

    usart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) bus_a ();
    usart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) bus_b ();
    usart_tx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) bus_c ();

    logic busy_a, tx_a, led_a;
    logic busy_b, tx_b, led_b;
    logic busy_c, tx_c, led_c;

    usart_tx_fifo #(.CLK_FREQ(400), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(0),
                    .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
        .clock(clock), .reset(reset), .bus(bus_a), .busy(busy_a), .tx(tx_a), .tx_led(led_a));
    usart_tx_fifo #(.CLK_FREQ(400), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(2),
                    .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
        .clock(clock), .reset(reset), .bus(bus_b), .busy(busy_b), .tx(tx_b), .tx_led(led_b));
    usart_tx_fifo #(.CLK_FREQ(400), .BAUD_RATE(100), .DATA_BITS(7), .PARITY(1),
                    .STOP_BITS(1), .FIFO_DEPTH(4)) dut_c (
        .clock(clock), .reset(reset), .bus(bus_c), .busy(busy_c), .tx(tx_c), .tx_led(led_c));

    // Expected frames, bit 0 = first bit on the line (start bit).
    logic [15:0] q_a[$];
    logic [15:0] q_b[$];
    logic [15:0] q_c[$];

    // Monitor state per instance.
    bit          in_frame [3];
    int          bit_i    [3];
    int          clk_i    [3];
    int          gap      [3];
    int          last_gap [3];
    int          frames   [3];
    logic [15:0] cap      [3];
    logic        cur      [3];
    bit          stable   [3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] build_frame(input logic [8:0] d, input int db,
                                                input int par, input int sb);
        logic [15:0] f;
        logic [8:0]  s;
        logic        p;
        int          n;
        int          ones;
        f    = '0;
        s    = d;
        n    = 0;
        ones = 0;
        f = {1'b0, f[15:1]};
        n++;
        for (int i = 0; i < db; i++) begin
            f    = {s[0], f[15:1]};
            ones += int'(s[0]);
            s    = s >> 1;
            n++;
        end
        if (par != 0) begin
            p = (par == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
            f = {p, f[15:1]};
            n++;
        end
        for (int i = 0; i < sb; i++) begin
            f = {1'b1, f[15:1]};
            n++;
        end
        return f >> (16 - n);
    endfunction

    function automatic logic get_busy(input int d);
        return (d == 0) ? busy_a : (d == 1) ? busy_b : busy_c;
    endfunction

    task automatic mon_step(input int d);
        logic        line;
        int          nb;
        int          qs;
        logic [15:0] expf;
        line = (d == 0) ? tx_a : (d == 1) ? tx_b : tx_c;
        nb   = (d == 1) ? 12 : 10;
        if (!in_frame[d] && line !== 1'b0) begin
            gap[d]++;
            return;
        end
        if (!in_frame[d]) begin
            in_frame[d] = 1'b1;
            bit_i[d]    = 0;
            clk_i[d]    = 0;
            cap[d]      = '0;
            stable[d]   = 1'b1;
            last_gap[d] = gap[d];
            gap[d]      = 0;
        end
        if (clk_i[d] == 0) begin
            cap[d] = {line, cap[d][15:1]};
            cur[d] = line;
        end else if (line !== cur[d]) begin
            stable[d] = 1'b0;
        end
        clk_i[d]++;
        if (clk_i[d] == DIV) begin
            clk_i[d] = 0;
            bit_i[d]++;
        end
        if (bit_i[d] == nb) begin
            in_frame[d] = 1'b0;
            frames[d]++;
            cap[d] = cap[d] >> (16 - nb);
            qs = (d == 0) ? q_a.size() : (d == 1) ? q_b.size() : q_c.size();
            if (qs == 0) begin
                check($sformatf("unexpected_frame_%0d", d), 32'(qs), 32'd1);
            end else begin
                case (d)
                    0:       expf = q_a.pop_front();
                    1:       expf = q_b.pop_front();
                    default: expf = q_c.pop_front();
                endcase
                check($sformatf("frame_%0d", d), {16'h0, cap[d]}, {16'h0, expf});
                check($sformatf("bit_stable_%0d", d), 32'(stable[d]), 32'd1);
            end
        end
    endtask

    always @(negedge clock or posedge reset) begin
        if (reset) begin
            for (int d = 0; d < 3; d++) begin
                in_frame[d] = 1'b0;
                gap[d]      = 0;
            end
        end else begin
            for (int d = 0; d < 3; d++) begin
                mon_step(d);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic wait_idle(input int d, input int max, output int cycles);
        cycles = 0;
        while (get_busy(d) && cycles < max) begin
            cycles++;
            tick();
        end
        check($sformatf("idle_reached_%0d", d), 32'(get_busy(d)), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        int          prev;
        int          n;
        bit          low_seen;
        logic [7:0]  words [5];

        for (int d = 0; d < 3; d++) begin
            in_frame[d] = 1'b0;
            bit_i[d]    = 0;
            clk_i[d]    = 0;
            gap[d]      = 0;
            last_gap[d] = -1;
            frames[d]   = 0;
            cap[d]      = '0;
            cur[d]      = 1'b1;
            stable[d]   = 1'b1;
        end
        bus_a.send = 1'b0; bus_a.data = '0;
        bus_b.send = 1'b0; bus_b.data = '0;
        bus_c.send = 1'b0; bus_c.data = '0;

        // Reset values, during and after reset.
        #1 reset = 1'b1;
        #2;
        check("rst_tx",       32'(tx_a),             32'd1);
        check("rst_busy",     32'(busy_a),           32'd0);
        check("rst_ready",    32'(bus_a.ready),      32'd1);
        check("rst_overflow", 32'(bus_a.overflow),   32'd0);
        check("rst_count",    32'(bus_a.fifo_count), 32'd0);
        check("rst_led",      32'(led_a),            32'd1);
        check("rst_tx_b",     32'(tx_b),             32'd1);
        check("rst_tx_c",     32'(tx_c),             32'd1);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        tick();
        check("post_rst_tx",  32'(tx_a),   32'd1);
        check("post_rst_led", 32'(led_a),  32'd1);

        // Single 8N1 frame, 0xA5.
        bus_a.data = 8'hA5;
        bus_a.send = 1'b1;
        q_a.push_back(build_frame(9'h0A5, 8, 0, 1));
        tick();
        bus_a.send = 1'b0;
        bus_a.data = 8'hFF;
        check("lat_count_queued", 32'(bus_a.fifo_count), 32'd1);
        check("lat_tx_still_idle", 32'(tx_a), 32'd1);
        check("lat_busy_low", 32'(busy_a), 32'd0);
        tick();
        check("start_tx_low", 32'(tx_a), 32'd0);
        check("start_busy", 32'(busy_a), 32'd1);
        check("start_count_popped", 32'(bus_a.fifo_count), 32'd0);
        check("start_led_low", 32'(led_a), 32'd0);
        wait_idle(0, 200, cyc);
        check("busy_len_8n1", 32'(cyc), 32'd40);
        check("led_back_8n1", 32'(led_a), 32'd1);

        // 8E2, 0xA5 then 0x01 back-to-back.
        bus_b.data = 8'hA5;
        bus_b.send = 1'b1;
        q_b.push_back(build_frame(9'h0A5, 8, 2, 2));
        tick();
        bus_b.data = 8'h01;
        q_b.push_back(build_frame(9'h001, 8, 2, 2));
        tick();
        bus_b.send = 1'b0;
        check("8e2_push_pop_count", 32'(bus_b.fifo_count), 32'd1);
        wait_idle(1, 300, cyc);
        check("busy_len_8e2x2", 32'(cyc), 32'd96);
        check("8e2_no_gap", 32'(last_gap[1]), 32'd0);
        check("8e2_frames", 32'(frames[1]), 32'd2);

        // 7O1, 0x7F: seven ones, odd parity bit 0.
        bus_c.data = 7'h7F;
        bus_c.send = 1'b1;
        q_c.push_back(build_frame(9'h07F, 7, 1, 1));
        tick();
        bus_c.send = 1'b0;
        tick();
        wait_idle(2, 200, cyc);
        check("busy_len_7o1", 32'(cyc), 32'd40);

        // FIFO full / overflow with a frame in flight.
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        words[3] = 8'h44; words[4] = 8'h55;
        bus_a.data = 8'h3C;
        bus_a.send = 1'b1;
        q_a.push_back(build_frame(9'h03C, 8, 0, 1));
        tick();
        bus_a.send = 1'b0;
        tick();
        check("ovf_frame_started", 32'(busy_a), 32'd1);
        for (int i = 0; i < 5; i++) begin
            bus_a.data = words[i];
            bus_a.send = 1'b1;
            if (i < 4) q_a.push_back(build_frame({1'b0, words[i]}, 8, 0, 1));
            tick();
            check($sformatf("fill_count_%0d", i), 32'(bus_a.fifo_count), (i < 4) ? 32'(i + 1) : 32'd4);
            check($sformatf("fill_ready_%0d", i), 32'(bus_a.ready), (i < 3) ? 32'd1 : 32'd0);
            check($sformatf("fill_overflow_%0d", i), 32'(bus_a.overflow), (i == 4) ? 32'd1 : 32'd0);
        end
        bus_a.send = 1'b0;
        bus_a.data = 8'hFF;
        tick();
        check("overflow_single_pulse", 32'(bus_a.overflow), 32'd0);
        prev = 4;
        for (int e = 3; e >= 0; e--) begin
            n = 0;
            while (bus_a.fifo_count == 3'(prev) && n < 80) begin
                tick();
                n++;
            end
            check($sformatf("drain_count_%0d", e), 32'(bus_a.fifo_count), 32'(e));
            if (e == 3) check("ready_after_pop", 32'(bus_a.ready), 32'd1);
            prev = e;
        end
        wait_idle(0, 200, cyc);
        check("drain_frames_in_order", 32'(q_a.size()), 32'd0);

        // Reset mid-DATA with three words queued.
        bus_a.data = 8'hC3; bus_a.send = 1'b1; q_a.push_back(build_frame(9'h0C3, 8, 0, 1));
        tick();
        bus_a.data = 8'h5A; q_a.push_back(build_frame(9'h05A, 8, 0, 1));
        tick();
        bus_a.data = 8'h96; q_a.push_back(build_frame(9'h096, 8, 0, 1));
        tick();
        bus_a.data = 8'h0F; q_a.push_back(build_frame(9'h00F, 8, 0, 1));
        tick();
        bus_a.send = 1'b0;
        check("rst_test_queued", 32'(bus_a.fifo_count), 32'd3);
        repeat (6) tick();
        check("rst_test_in_frame", 32'(busy_a), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("midrst_tx",    32'(tx_a),             32'd1);
        check("midrst_busy",  32'(busy_a),           32'd0);
        check("midrst_count", 32'(bus_a.fifo_count), 32'd0);
        check("midrst_ready", 32'(bus_a.ready),      32'd1);
        q_a.delete();
        @(negedge clock);
        reset = 1'b0;
        low_seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (tx_a !== 1'b1 || busy_a !== 1'b0) low_seen = 1'b1;
        end
        check("post_midrst_quiet", 32'(low_seen), 32'd0);

        // Simultaneous push and pop at the end of a frame.
        bus_a.data = 8'h81; bus_a.send = 1'b1; q_a.push_back(build_frame(9'h081, 8, 0, 1));
        tick();
        bus_a.send = 1'b0;
        tick();
        bus_a.data = 8'h42; bus_a.send = 1'b1; q_a.push_back(build_frame(9'h042, 8, 0, 1));
        tick();
        bus_a.send = 1'b0;
        check("pp_pre_count", 32'(bus_a.fifo_count), 32'd1);
        repeat (38) tick();
        bus_a.data = 8'hE7; bus_a.send = 1'b1; q_a.push_back(build_frame(9'h0E7, 8, 0, 1));
        tick();
        bus_a.send = 1'b0;
        check("pp_count_held", 32'(bus_a.fifo_count), 32'd1);
        check("pp_next_start", 32'(tx_a), 32'd0);
        check("pp_busy_held", 32'(busy_a), 32'd1);
        wait_idle(0, 300, cyc);
        check("pp_busy_len", 32'(cyc), 32'd80);
        check("pp_no_gap", 32'(last_gap[0]), 32'd0);

        check("sb_empty_a", 32'(q_a.size()), 32'd0);
        check("sb_empty_b", 32'(q_b.size()), 32'd0);
        check("sb_empty_c", 32'(q_c.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
